// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU-side and writeback signals of the ALU issue controller.
// slave = the controller, master = whatever drives instructions and hosts the ALU.
interface alu_issue_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs;
  logic [7:0] instr_imm;
  logic       instr_use_imm;
  logic       instr_use_carry;
  logic [2:0] instr_shamt;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cin;
  logic [3:0] alu_opcode;
  logic [2:0] alu_shift_amt;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       alu_zero;
  logic       alu_sign;
  logic       alu_overflow;

  logic       wb_valid;
  logic       wb_ready;
  logic [7:0] wb_data;
  logic [1:0] wb_rd;
  logic [3:0] wb_flags;

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_imm,
           instr_use_imm, instr_use_carry, instr_shamt,
           alu_res, alu_cout, alu_zero, alu_sign, alu_overflow, wb_ready,
    output instr_ready, alu_a, alu_b, alu_cin, alu_opcode, alu_shift_amt,
           wb_valid, wb_data, wb_rd, wb_flags
  );

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_imm,
           instr_use_imm, instr_use_carry, instr_shamt,
           alu_res, alu_cout, alu_zero, alu_sign, alu_overflow, wb_ready,
    input  instr_ready, alu_a, alu_b, alu_cin, alu_opcode, alu_shift_amt,
           wb_valid, wb_data, wb_rd, wb_flags
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the 8-bit combinational ALU: 4x8 register file,
// {C,Z,N,V} flag register, IDLE -> EXEC -> WB per instruction.
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_ctrl_if.slave   bus,
  output logic [3:0]        flags,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t     state, state_nxt;
  logic [7:0] regs [4];
  logic [1:0] rd_q;
  logic       reserved;
  logic       movi;
  logic [7:0] cap_data;
  logic [3:0] cap_flags;

  // The latched opcode lives in alu_opcode, so decode straight from it in EXEC.
  assign reserved = (bus.alu_opcode >= 4'b1101);
  assign movi     = (bus.alu_opcode == 4'b1100);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.instr_ready = 1'b0;
    bus.wb_valid    = 1'b0;
    illegal         = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (reserved) begin
          illegal   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WB;
        end
      end
      WB: begin
        bus.wb_valid = 1'b1;
        if (bus.wb_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flags cannot change between accept and capture, so flags[3] is the accept-time C.
  always_comb begin
    cap_data  = bus.alu_res;
    cap_flags = {flags[3], bus.alu_zero, bus.alu_sign, bus.alu_overflow};
    if (movi) begin
      cap_data  = bus.alu_b;
      cap_flags = {flags[3], (bus.alu_b == '0), bus.alu_b[7], 1'b0};
    end else if (bus.alu_opcode[3:1] == 3'b000) begin
      cap_flags[3] = bus.alu_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
      flags             <= '0;
      retired           <= '0;
      rd_q              <= '0;
      bus.alu_a         <= '0;
      bus.alu_b         <= '0;
      bus.alu_cin       <= 1'b0;
      bus.alu_opcode    <= '0;
      bus.alu_shift_amt <= '0;
      bus.wb_data       <= '0;
      bus.wb_rd         <= '0;
      bus.wb_flags      <= '0;
    end else begin
      if (state == IDLE && bus.instr_valid) begin
        bus.alu_a         <= regs[bus.instr_rd];
        bus.alu_b         <= bus.instr_use_imm ? bus.instr_imm : regs[bus.instr_rs];
        bus.alu_opcode    <= bus.instr_op;
        bus.alu_shift_amt <= bus.instr_shamt;
        bus.alu_cin       <= bus.instr_use_carry & flags[3];
        rd_q              <= bus.instr_rd;
      end
      if (state == EXEC && !reserved) begin
        bus.wb_data  <= cap_data;
        bus.wb_flags <= cap_flags;
        bus.wb_rd    <= rd_q;
      end
      if (state == WB && bus.wb_ready) begin
        regs[bus.wb_rd] <= bus.wb_data;
        flags           <= bus.wb_flags;
        retired         <= retired + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU stub, vector table, scoreboard of writebacks,
// plus hand-written stall / reserved-opcode / reset / counter-wrap sequences.
module tb_alu_issue_ctrl;
  localparam int TB_CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] flags;
  logic illegal;
  logic [TB_CNT_W-1:0] retired;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flags(flags), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  // ALU stub; non-add ops and MOVI/reserved drive junk cout/overflow so ignored outputs show up.
  logic [8:0]  sum;
  logic [15:0] rot;
  always_comb begin
    sum = '0;
    rot = '0;
    bus.alu_res      = 8'h00;
    bus.alu_cout     = 1'b1;
    bus.alu_overflow = 1'b0;
    case (bus.alu_opcode)
      4'h0: begin
        sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'b0, bus.alu_cin};
        bus.alu_res = sum[7:0];
        bus.alu_cout = sum[8];
        bus.alu_overflow = (bus.alu_a[7] == bus.alu_b[7]) && (sum[7] != bus.alu_a[7]);
      end
      4'h1: begin
        sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {8'b0, bus.alu_cin};
        bus.alu_res = sum[7:0];
        bus.alu_cout = sum[8];
        bus.alu_overflow = (bus.alu_a[7] != bus.alu_b[7]) && (sum[7] != bus.alu_a[7]);
      end
      4'h2: bus.alu_res = bus.alu_a & bus.alu_b;
      4'h3: bus.alu_res = bus.alu_a | bus.alu_b;
      4'h4: bus.alu_res = bus.alu_a ^ bus.alu_b;
      4'h5: bus.alu_res = ~bus.alu_a;
      4'h6: bus.alu_res = bus.alu_a << bus.alu_shift_amt;
      4'h7: bus.alu_res = bus.alu_a >> bus.alu_shift_amt;
      4'h8: bus.alu_res = 8'($signed(bus.alu_a) >>> bus.alu_shift_amt);
      4'h9: bus.alu_res = bus.alu_b;
      4'hA: begin rot = {bus.alu_a, bus.alu_a} << bus.alu_shift_amt; bus.alu_res = rot[15:8]; end
      4'hB: begin rot = {bus.alu_a, bus.alu_a} >> bus.alu_shift_amt; bus.alu_res = rot[7:0]; end
      default: begin bus.alu_res = 8'hA5; bus.alu_overflow = 1'b1; end
    endcase
    bus.alu_zero = (bus.alu_res == 8'h00);
    bus.alu_sign = bus.alu_res[7];
  end

  typedef struct {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       use_imm;
    logic       use_carry;
    logic [2:0] shamt;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_cin;
    logic [7:0] exp_data;
    logic [3:0] exp_flags;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] rd;
    logic [3:0] flags;
  } exp_t;

  exp_t sb [$];
  vec_t tbl [12];
  int checks = 0;
  int errors = 0;
  logic [TB_CNT_W-1:0] model_ret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.instr_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) begin
      checks++;
      errors++;
      $display("FAIL instr_ready_timeout: got 0 expected 1");
    end
  endtask

  // Drives one instruction at a negedge in IDLE, returns at the EXEC negedge.
  task automatic issue(input vec_t v, input bit retires);
    wait_ready();
    bus.instr_valid     = 1'b1;
    bus.instr_op        = v.op;
    bus.instr_rd        = v.rd;
    bus.instr_rs        = v.rs;
    bus.instr_imm       = v.imm;
    bus.instr_use_imm   = v.use_imm;
    bus.instr_use_carry = v.use_carry;
    bus.instr_shamt     = v.shamt;
    if (retires) sb.push_back('{v.exp_data, v.rd, v.exp_flags});
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("exec_instr_ready", 32'(bus.instr_ready), 32'd0);
    check("alu_a", 32'(bus.alu_a), 32'(v.exp_a));
    check("alu_b", 32'(bus.alu_b), 32'(v.exp_b));
    check("alu_cin", 32'(bus.alu_cin), 32'(v.exp_cin));
    check("alu_opcode", 32'(bus.alu_opcode), 32'(v.op));
    check("alu_shift_amt", 32'(bus.alu_shift_amt), 32'(v.shamt));
  endtask

  task automatic run_retiring(input vec_t v);
    issue(v, 1'b1);
    wait_ready();
    model_ret++;
    check("flags", 32'(flags), 32'(v.exp_flags));
    check("retired", 32'(retired), 32'(model_ret));
  endtask

  // Handshake decided at the next posedge from inputs driven at the negedge.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && bus.wb_valid && bus.wb_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got writeback data %0h expected none", bus.wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_data", 32'(bus.wb_data), 32'(e.data));
        check("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
        check("wb_flags", 32'(bus.wb_flags), 32'(e.flags));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0]  = '{4'hC, 2'd0, 2'd0, 8'h7F, 1'b1, 1'b0, 3'd0, 8'h00, 8'h7F, 1'b0, 8'h7F, 4'b0000};
    tbl[1]  = '{4'hC, 2'd1, 2'd0, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 8'h01, 1'b0, 8'h01, 4'b0000};
    tbl[2]  = '{4'h0, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011};
    tbl[3]  = '{4'hC, 2'd2, 2'd0, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 8'hFF, 4'b0010};
    tbl[4]  = '{4'h0, 2'd2, 2'd0, 8'h01, 1'b1, 1'b0, 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100};
    tbl[5]  = '{4'h0, 2'd3, 2'd0, 8'h00, 1'b1, 1'b1, 3'd0, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0000};
    tbl[6]  = '{4'hC, 2'd1, 2'd0, 8'h81, 1'b1, 1'b0, 3'd0, 8'h01, 8'h81, 1'b0, 8'h81, 4'b0010};
    tbl[7]  = '{4'hA, 2'd1, 2'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h81, 8'h00, 1'b0, 8'h03, 4'b0000};
    tbl[8]  = '{4'h1, 2'd0, 2'd1, 8'h00, 1'b0, 1'b1, 3'd0, 8'h80, 8'h03, 1'b0, 8'h7D, 4'b0001};
    tbl[9]  = '{4'h2, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h7D, 8'h7D, 1'b0, 8'h7D, 4'b0000};
    tbl[10] = '{4'hC, 2'd3, 2'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 8'h7D, 1'b0, 8'h7D, 4'b0000};
    tbl[11] = '{4'h6, 2'd3, 2'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h7D, 8'h00, 1'b0, 8'hFA, 4'b0010};

    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_op = '0;
    bus.instr_rd = '0;
    bus.instr_rs = '0;
    bus.instr_imm = '0;
    bus.instr_use_imm = 1'b0;
    bus.instr_use_carry = 1'b0;
    bus.instr_shamt = '0;
    bus.wb_ready = 1'b1;
    model_ret = '0;
    repeat (2) @(negedge clk);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_alu", {bus.alu_a, bus.alu_b, 4'(bus.alu_opcode), 3'(bus.alu_shift_amt), bus.alu_cin, 8'h00}, 32'd0);
    check("rst_wb_regs", 32'({bus.wb_data, bus.wb_rd, bus.wb_flags}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_instr_ready", 32'(bus.instr_ready), 32'd1);

    for (int i = 0; i < 12; i++) run_retiring(tbl[i]);

    // wb_ready held low for 10 cycles while another instruction is being offered.
    v = '{4'hC, 2'd2, 2'd0, 8'h3C, 1'b1, 1'b0, 3'd0, 8'h00, 8'h3C, 1'b0, 8'h3C, 4'b0000};
    issue(v, 1'b1);
    bus.wb_ready = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr_op = 4'hC;
    bus.instr_rd = 2'd0;
    bus.instr_imm = 8'hEE;
    bus.instr_use_imm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_wb_valid", 32'(bus.wb_valid), 32'd1);
      check("stall_wb_data", 32'(bus.wb_data), 32'h3C);
      check("stall_instr_ready", 32'(bus.instr_ready), 32'd0);
    end
    bus.instr_valid = 1'b0;
    bus.wb_ready = 1'b1;
    wait_ready();
    model_ret++;
    check("stall_retired", 32'(retired), 32'(model_ret));
    check("stall_flags", 32'(flags), 32'd0);

    // Reserved opcode; alu_a also proves R0 kept 0x7D through the stalled offer.
    v = '{4'hE, 2'd0, 2'd1, 8'h00, 1'b0, 1'b0, 3'd2, 8'h7D, 8'h03, 1'b0, 8'h00, 4'b0000};
    issue(v, 1'b0);
    check("illegal_pulse", 32'(illegal), 32'd1);
    check("illegal_wb_valid", 32'(bus.wb_valid), 32'd0);
    @(negedge clk);
    check("illegal_clear", 32'(illegal), 32'd0);
    check("illegal_ready_back", 32'(bus.instr_ready), 32'd1);
    check("illegal_wb_valid2", 32'(bus.wb_valid), 32'd0);
    check("illegal_flags", 32'(flags), 32'd0);
    check("illegal_retired", 32'(retired), 32'(model_ret));

    // Reset while a MOVI is in EXEC.
    v = '{4'hC, 2'd2, 2'd0, 8'h55, 1'b1, 1'b0, 3'd0, 8'h3C, 8'h55, 1'b0, 8'h55, 4'b0000};
    issue(v, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("midrst_alu", {bus.alu_a, bus.alu_b, 4'(bus.alu_opcode), 3'(bus.alu_shift_amt), bus.alu_cin, 8'h00}, 32'd0);
    check("midrst_wb_regs", 32'({bus.wb_data, bus.wb_rd, bus.wb_flags}), 32'd0);
    check("midrst_retired", 32'(retired), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ret = '0;
    v = '{4'hC, 2'd3, 2'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0100};
    run_retiring(v);

    // Counter wrap: 16 retirements since reset brings the 4-bit count back to 0.
    for (int i = 0; i < 15; i++) begin
      v = '{4'hC, 2'd0, 2'd0, 8'(i + 1), 1'b1, 1'b0, 3'd0, 8'(i), 8'(i + 1), 1'b0, 8'(i + 1), 4'b0000};
      run_retiring(v);
      if (i == 13) check("retired_max", 32'(retired), 32'hF);
    end
    check("retired_wrap", 32'(retired), 32'd0);

    @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing stage that sits directly upstream of the 8-bit ALU (4-bit opcode, 3-bit shift amount, cin, a/b operands, res/cout/zero/sign/overflow outputs).
- Accepts instructions over a valid/ready handshake and reads operands from a 4x8 register file. It drives the ALU's combinational inputs, captures its result and flags, and writes back.
- Holds the architectural flag register {C,Z,N,V} and presents each retired result downstream over a second valid/ready handshake.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept instruction
instr_op  in  4  ALU opcode 0000-1011; 1100 = MOVI; 1101-1111 reserved
instr_rd  in  2  destination register / operand A register
instr_rs  in  2  operand B register
instr_imm  in  8  immediate (B operand when instr_use_imm, MOVI data)
instr_use_imm  in  1  B = instr_imm instead of R[rs]
instr_use_carry  in  1  cin = flag C (else cin = 0)
instr_shamt  in  3  shift/rotate amount
alu_a  out  8  ALU operand a
alu_b  out  8  ALU operand b
alu_cin  out  1  ALU carry-in
alu_opcode  out  4  ALU opcode
alu_shift_amt  out  3  ALU shift amount
alu_res  in  8  ALU result
alu_cout  in  1  ALU carry-out
alu_zero  in  1  ALU zero flag
alu_sign  in  1  ALU sign flag
alu_overflow  in  1  ALU overflow flag
wb_valid  out  1  result available
wb_ready  in  1  downstream accepts result
wb_data  out  8  result value
wb_rd  out  2  destination register index
wb_flags  out  4  {C,Z,N,V} as they will be after this writeback
flags  out  4  architectural flag register {C,Z,N,V}
illegal  out  1  one-cycle pulse on reserved opcode
retired  out  CNT_W  count of completed writebacks

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; R0-R3 = 0; flags = 0; retired = 0.
  - wb_valid = 0; illegal = 0; all alu_* outputs = 0; wb_data/wb_rd/wb_flags = 0.
  - Reset asserted mid-instruction abandons it: no writeback, no counter increment.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid, latch op, rd, shamt, use_carry. Latch A = R[rd] and B = (use_imm ? imm : R[rs]) from the register values current in that cycle.
  - Go to EXEC.
- EXEC (exactly one cycle):
  - instr_ready = 0.
  - Drive alu_a = A, alu_b = B, alu_opcode = op, alu_shift_amt = shamt, alu_cin = use_carry & C (C sampled at accept).
  - ALU is combinational; at the end of the cycle, capture wb_data and wb_flags as follows, then go to WB:
    - ALU ops 0000-1011: wb_data = alu_res. C' = alu_cout for 0000/0001, otherwise C unchanged. Z' = alu_zero, N' = alu_sign, V' = alu_overflow.
    - MOVI (1100): ALU outputs ignored. wb_data = B (immediate or R[rs]). Z/N from data, V' = 0, C unchanged.
    - Reserved (1101-1111): pulse illegal for one cycle, no capture, go to IDLE. Flags, registers and retired are unchanged.
- WB:
  - wb_valid = 1; wb_data, wb_rd and wb_flags are held stable until the handshake.
  - On wb_valid & wb_ready: R[rd] <= wb_data, flags <= wb_flags, retired += 1 (wrapping at 2^CNT_W), go to IDLE.
  - wb_ready low stalls indefinitely; instr_ready stays 0.
- Latency: accept in cycle N, ALU driven in N+1, wb_valid from N+2. Minimum issue interval is 3 cycles when wb_ready is held at 1.
- Back-to-back dependence: an instruction accepted in the cycle after a writeback sees the updated register and flags (writeback completes before re-entry to IDLE).
- alu_* outputs hold their last values outside EXEC.
- rd == rs is legal; both operands read the same register.

Test Plan:
- MOVI R0=0x7F; MOVI R1=0x01; ADD (rd=0, rs=1) -> wb_data=0x80, flags C=0 Z=0 N=1 V=1, R0=0x80, retired=3.
- MOVI R2=0xFF; ADD imm 0x01 to R2 (use_carry=0) -> 0x00, C=1 Z=1 N=0 V=0. Then ADD imm 0x00 to R3(=0) with use_carry=1 -> alu_cin=1 in EXEC, result 0x01, C=0.
- MOVI R1=0x81; ROTL (1010) R1 with shamt=1 -> wb_data=0x03, N=0, and C stays at its previous value.
- Opcode 1110 offered -> illegal high for exactly 1 cycle, no wb_valid, registers, flags and retired unchanged; instr_ready back to 1 two cycles after accept.
- Hold wb_ready=0 for 10 cycles during WB -> wb_valid/wb_data stable, instr_ready=0, no instruction accepted. Release -> single write, retired +1.
- Assert rst_n=0 in EXEC after a MOVI -> all outputs zero immediately, register unchanged (0), retired=0. Preload retired=0xFFFF and retire one more -> retired=0x0000.
